// File: rtl/bscan_chain_ctl.sv
// Boundary-scan chain controller: capture / shift / update sequencing of the
// pad-ring scan stitch, with a divided scan clock and registered outputs.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | waiting for start, outputs quiet
//   CAPTURE | one scan clock pulse with shift low, pads sample their pins
//   SHIFT   | CHAIN_LEN scan clock pulses, vector out / captured vector in
//   UPDATE  | update strobe for DIV cycles, pads latch the shifted vector
//   DONE    | one-cycle completion pulse, captured data published
module bscan_chain_ctl #(
  parameter int CHAIN_LEN = 43,
  parameter int DIV       = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 mode_in,
  input  logic [CHAIN_LEN-1:0] load_data,
  input  logic                 bscan_so,
  output logic                 bscan_si,
  output logic                 bscan_shift,
  output logic                 bscan_clock,
  output logic                 bscan_update,
  output logic                 bscan_mode,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] cap_data
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_SHIFT,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t               state, state_n;
  logic [DW-1:0]        div_cnt, div_n;
  logic                 hi, hi_n;
  logic [CW-1:0]        bit_cnt, bit_n;
  logic [CHAIN_LEN-1:0] load_sreg, load_n;
  logic [CHAIN_LEN-1:0] cap_sreg, capsr_n;
  logic [CHAIN_LEN-1:0] cap_n;
  logic                 si_n, shift_n, clock_n, update_n, mode_n, busy_n, done_n;
  logic                 phase_end;

  // The phase timer is a down-counter; zero marks the last cycle of a phase.
  assign phase_end = (div_cnt == '0);

  // State, timers, shift registers and all outputs are registered together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      hi           <= 1'b0;
      bit_cnt      <= '0;
      load_sreg    <= '0;
      cap_sreg     <= '0;
      cap_data     <= '0;
      bscan_si     <= 1'b0;
      bscan_shift  <= 1'b0;
      bscan_clock  <= 1'b0;
      bscan_update <= 1'b0;
      bscan_mode   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      div_cnt      <= div_n;
      hi           <= hi_n;
      bit_cnt      <= bit_n;
      load_sreg    <= load_n;
      cap_sreg     <= capsr_n;
      cap_data     <= cap_n;
      bscan_si     <= si_n;
      bscan_shift  <= shift_n;
      bscan_clock  <= clock_n;
      bscan_update <= update_n;
      bscan_mode   <= mode_n;
      busy         <= busy_n;
      done         <= done_n;
    end
  end

  // Next-state and next-output decode; outputs are computed one cycle ahead
  // so that the registered values line up with the state they belong to.
  always_comb begin
    state_n  = state;
    div_n    = div_cnt;
    hi_n     = hi;
    bit_n    = bit_cnt;
    load_n   = load_sreg;
    capsr_n  = cap_sreg;
    cap_n    = cap_data;
    si_n     = bscan_si;
    shift_n  = bscan_shift;
    clock_n  = bscan_clock;
    update_n = bscan_update;
    mode_n   = bscan_mode;
    busy_n   = busy;
    done_n   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_CAPTURE;
          load_n  = load_data;
          mode_n  = mode_in;
          busy_n  = 1'b1;
          div_n   = DIV_LAST;
          hi_n    = 1'b0;
          clock_n = 1'b0;
          shift_n = 1'b0;
        end
      end

      S_CAPTURE: begin
        if (!phase_end) begin
          div_n = div_cnt - 1'b1;
        end else if (!hi) begin
          hi_n    = 1'b1;
          clock_n = 1'b1;
          div_n   = DIV_LAST;
        end else begin
          // First shift bit goes out together with the falling clock.
          state_n = S_SHIFT;
          hi_n    = 1'b0;
          clock_n = 1'b0;
          shift_n = 1'b1;
          div_n   = DIV_LAST;
          bit_n   = '0;
          si_n    = load_sreg[CHAIN_LEN-1];
          load_n  = load_sreg << 1;
        end
      end

      S_SHIFT: begin
        if (!phase_end) begin
          div_n = div_cnt - 1'b1;
        end else if (!hi) begin
          // Sample the returning bit just before the scan clock rises.
          hi_n    = 1'b1;
          clock_n = 1'b1;
          div_n   = DIV_LAST;
          capsr_n = (cap_sreg << 1) | CHAIN_LEN'(bscan_so);
        end else if (bit_cnt == LAST_BIT) begin
          state_n  = S_UPDATE;
          hi_n     = 1'b0;
          clock_n  = 1'b0;
          shift_n  = 1'b0;
          update_n = 1'b1;
          si_n     = 1'b0;
          div_n    = DIV_LAST;
        end else begin
          bit_n   = bit_cnt + 1'b1;
          hi_n    = 1'b0;
          clock_n = 1'b0;
          div_n   = DIV_LAST;
          si_n    = load_sreg[CHAIN_LEN-1];
          load_n  = load_sreg << 1;
        end
      end

      S_UPDATE: begin
        if (!phase_end) begin
          div_n = div_cnt - 1'b1;
        end else begin
          state_n  = S_DONE;
          update_n = 1'b0;
          busy_n   = 1'b0;
          done_n   = 1'b1;
          cap_n    = cap_sreg;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bscan_chain_ctl.sv
// Bench for bscan_chain_ctl: a 43-stage/DIV=2 instance and a 4-stage/DIV=1
// instance, each with a behavioural pad chain, a done-driven scoreboard and a
// protocol checker.
module tb_bscan_chain_ctl;

  localparam int LA = 43;
  localparam int DA = 2;
  localparam int LS = 4;
  localparam int DS = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- large instance ----------------
  logic          rst_a, start_a, mode_in_a, so_a;
  logic [LA-1:0] load_a, cap_a, pins_a, stg_a;
  logic          si_a, shift_a, clock_a, update_a, mode_a, busy_a, done_a;

  bscan_chain_ctl #(.CHAIN_LEN(LA), .DIV(DA)) dut_a (
    .clk(clk), .reset_n(rst_a), .start(start_a), .mode_in(mode_in_a),
    .load_data(load_a), .bscan_so(so_a), .bscan_si(si_a), .bscan_shift(shift_a),
    .bscan_clock(clock_a), .bscan_update(update_a), .bscan_mode(mode_a),
    .busy(busy_a), .done(done_a), .cap_data(cap_a)
  );

  initial stg_a = '0;
  assign so_a = stg_a[LA-1];
  always @(posedge clock_a) begin
    if (shift_a) stg_a <= {stg_a[LA-2:0], si_a};
    else         stg_a <= pins_a;
  end

  int   lo_a = 0, hi_a = 0, viol_a = 0;
  logic pclk_a = 1'b0, psi_a = 1'b0;
  always @(negedge clk) begin
    if (shift_a && update_a) viol_a++;
    if (clock_a && (si_a !== psi_a)) viol_a++;
    if (!rst_a || !busy_a) begin
      lo_a = 0; hi_a = 0;
    end else if (clock_a) begin
      if (!pclk_a && lo_a != DA) viol_a++;
      hi_a++; lo_a = 0;
    end else begin
      if (pclk_a && hi_a != DA) viol_a++;
      lo_a++; hi_a = 0;
    end
    pclk_a = clock_a;
    psi_a  = si_a;
  end

  typedef struct {
    int          done_cyc;
    logic [LA-1:0] cap;
    logic        mode;
    logic [LA-1:0] stg;
  } exp_a_t;
  exp_a_t qa[$];
  exp_a_t ea;

  always @(negedge clk) begin
    if (done_a) begin
      if (qa.size() == 0) begin
        n_checks++;
        $display("FAIL a_unexpected_done: done at cycle %0d, none expected", cyc);
      end else begin
        ea = qa.pop_front();
        check("a_done_cycle", cyc, ea.done_cyc);
        check("a_cap_data", cap_a, ea.cap);
        check("a_bscan_mode", mode_a, ea.mode);
        check("a_chain_stages", stg_a, ea.stg);
      end
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_done_a(input int limit);
    while (!done_a && cyc < limit) @(negedge clk);
    if (!done_a) begin
      n_checks++;
      $display("FAIL a_done_timeout: no done by cycle %0d", cyc);
    end
  endtask

  task automatic push_a(input int dc, input logic [LA-1:0] cap, input logic md, input logic [LA-1:0] stg);
    exp_a_t e;
    e.done_cyc = dc; e.cap = cap; e.mode = md; e.stg = stg;
    qa.push_back(e);
  endtask

  logic fin_a = 1'b0;
  initial begin
    int t, tb2, tc, td;
    rst_a = 1'b0; start_a = 1'b0; mode_in_a = 1'b0; load_a = '0; pins_a = '0;
    repeat (3) @(negedge clk);
    check("a_reset_outputs", {si_a, shift_a, clock_a, update_a, mode_a, busy_a, done_a}, 7'd0);
    check("a_reset_cap", cap_a, '0);
    rst_a = 1'b1;
    @(negedge clk);

    // walking pattern, with ignored starts at cycles 5, 100 and in DONE
    t = cyc;
    load_a = 43'h2AA_AAAA_AAAA; pins_a = 43'h155_5555_5555; mode_in_a = 1'b0; start_a = 1'b1;
    push_a(t + 179, 43'h155_5555_5555, 1'b0, 43'h2AA_AAAA_AAAA);
    @(negedge clk); start_a = 1'b0;
    check("a_busy_rise", busy_a, 1'b1);
    wait_to(t + 5);
    start_a = 1'b1; mode_in_a = 1'b1; load_a = '1;
    @(negedge clk); start_a = 1'b0;
    wait_to(t + 100);
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_done_a(t + 300);

    // start held over DONE and the following cycle: only the second is taken
    load_a = 43'h0F0_F0F0_F0F0; pins_a = 43'h5A5_A5A5_A5A5; mode_in_a = 1'b1; start_a = 1'b1;
    @(negedge clk);
    tb2 = cyc;
    check("a_done_cycle_start_ignored", busy_a, 1'b0);
    push_a(tb2 + 179, 43'h5A5_A5A5_A5A5, 1'b1, 43'h0F0_F0F0_F0F0);
    @(negedge clk); start_a = 1'b0; mode_in_a = 1'b0;
    check("a_back_to_back_busy", busy_a, 1'b1);
    wait_to(tb2 + 100);
    check("a_cap_hold_until_done", cap_a, 43'h155_5555_5555);
    wait_done_a(tb2 + 300);
    repeat (2) @(negedge clk);

    // reset in the middle of a shift
    tc = cyc;
    load_a = 43'h3FF_FFFF_FFFF; mode_in_a = 1'b1; start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_to(tc + 60);
    check("a_in_shift_before_reset", shift_a, 1'b1);
    #2 rst_a = 1'b0;
    #1;
    check("a_async_reset_outputs", {si_a, shift_a, clock_a, update_a, mode_a, busy_a, done_a}, 7'd0);
    check("a_async_reset_cap", cap_a, '0);
    @(negedge clk); rst_a = 1'b1;
    @(negedge clk);

    // fresh operation after reset
    td = cyc;
    load_a = 43'h123_4567_89AB; pins_a = 43'h7ED_CBA9_8765; mode_in_a = 1'b0; start_a = 1'b1;
    push_a(td + 179, 43'h7ED_CBA9_8765, 1'b0, 43'h123_4567_89AB);
    @(negedge clk); start_a = 1'b0;
    wait_done_a(td + 300);
    repeat (5) @(negedge clk);
    check("a_scoreboard_drained", qa.size(), 0);
    check("a_protocol_violations", viol_a, 0);
    fin_a = 1'b1;
  end

  // ---------------- small instance ----------------
  logic          rst_s, start_s, mode_in_s, so_s;
  logic [LS-1:0] load_s, cap_s, pins_s, stg_s, siseq_s;
  logic          si_s, shift_s, clock_s, update_s, mode_s, busy_s, done_s;
  int            rises_s = 0, upd_s = 0;

  bscan_chain_ctl #(.CHAIN_LEN(LS), .DIV(DS)) dut_s (
    .clk(clk), .reset_n(rst_s), .start(start_s), .mode_in(mode_in_s),
    .load_data(load_s), .bscan_so(so_s), .bscan_si(si_s), .bscan_shift(shift_s),
    .bscan_clock(clock_s), .bscan_update(update_s), .bscan_mode(mode_s),
    .busy(busy_s), .done(done_s), .cap_data(cap_s)
  );

  initial begin stg_s = '0; siseq_s = '0; end
  assign so_s = stg_s[LS-1];
  always @(posedge clock_s) begin
    rises_s++;
    if (shift_s) begin
      stg_s   <= {stg_s[LS-2:0], si_s};
      siseq_s <= {siseq_s[LS-2:0], si_s};
    end else begin
      stg_s <= pins_s;
    end
  end

  int   lo_s = 0, hi_s = 0, viol_s = 0;
  logic pclk_s = 1'b0, psi_s = 1'b0;
  always @(negedge clk) begin
    if (update_s) upd_s++;
    if (shift_s && update_s) viol_s++;
    if (clock_s && (si_s !== psi_s)) viol_s++;
    if (!rst_s || !busy_s) begin
      lo_s = 0; hi_s = 0;
    end else if (clock_s) begin
      if (!pclk_s && lo_s != DS) viol_s++;
      hi_s++; lo_s = 0;
    end else begin
      if (pclk_s && hi_s != DS) viol_s++;
      lo_s++; hi_s = 0;
    end
    pclk_s = clock_s;
    psi_s  = si_s;
  end

  typedef struct {
    int          done_cyc;
    logic [LS-1:0] cap;
    logic [LS-1:0] stg;
    logic [LS-1:0] siseq;
    int          rises;
    int          upd;
  } exp_s_t;
  exp_s_t qs[$];
  exp_s_t es;

  always @(negedge clk) begin
    if (done_s) begin
      if (qs.size() == 0) begin
        n_checks++;
        $display("FAIL s_unexpected_done: done at cycle %0d, none expected", cyc);
      end else begin
        es = qs.pop_front();
        check("s_done_cycle", cyc, es.done_cyc);
        check("s_cap_data", cap_s, es.cap);
        check("s_chain_stages", stg_s, es.stg);
        check("s_si_sequence", siseq_s, es.siseq);
        check("s_clock_rises", rises_s, es.rises);
        check("s_update_cycles", upd_s, es.upd);
      end
    end
  end

  logic fin_s = 1'b0;
  initial begin
    int t;
    exp_s_t e;
    rst_s = 1'b0; start_s = 1'b0; mode_in_s = 1'b0; load_s = '0; pins_s = '0;
    repeat (3) @(negedge clk);
    rst_s = 1'b1;
    repeat (2) @(negedge clk);
    rises_s = 0; upd_s = 0;
    t = cyc;
    load_s = 4'b1001; pins_s = 4'b0110; start_s = 1'b1;
    e.done_cyc = t + 12; e.cap = 4'b0110; e.stg = 4'b1001; e.siseq = 4'b1001;
    e.rises = 5; e.upd = 1;
    qs.push_back(e);
    @(negedge clk); start_s = 1'b0;
    while (!done_s && cyc < t + 40) @(negedge clk);
    if (!done_s) begin
      n_checks++;
      $display("FAIL s_done_timeout: no done by cycle %0d", cyc);
    end
    repeat (3) @(negedge clk);
    check("s_scoreboard_drained", qs.size(), 0);
    check("s_protocol_violations", viol_s, 0);
    fin_s = 1'b1;
  end

  // ---------------- end of run ----------------
  initial begin
    wait (fin_a && fin_s);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
